// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: PC sequencing, stalls,
// execute redirects, HALT and misaligned-redirect error trapping.
module fetch_stage #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_ready,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc2,
    output logic             if_valid,
    output logic             fetch_err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERR    = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc2;
        logic             valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc2: '0, valid: 1'b0};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus2;
    if_id_t           ifid_q, ifid_d;
    logic             err_q, err_d;
    logic             is_halt;

    assign pc_plus2 = pc_q + WIDTH'(2);
    assign is_halt  = (imem_data[WIDTH-1 -: 5] == 5'b00000);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        err_d   = err_q;
        if (state_q == ERR) begin
            state_d = ERR;
        end else if (redirect && redirect_pc[0]) begin
            err_d   = 1'b1;
            state_d = ERR;
            ifid_d  = BUBBLE;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            ifid_d  = BUBBLE;
            state_d = RUN;
        end else if (stall) begin
            state_d = state_q;
        end else if (state_q == HALTED || !imem_ready) begin
            ifid_d = BUBBLE;
        end else begin
            ifid_d.instr = imem_data;
            ifid_d.pc2   = pc_plus2;
            ifid_d.valid = 1'b1;
            // HALT parks the PC on itself so a squash can resume cleanly
            if (is_halt) state_d = HALTED;
            else         pc_d    = pc_plus2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= BUBBLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_rd   = (state_q == RUN);
    assign if_instr  = ifid_q.instr;
    assign if_pc2    = ifid_q.pc2;
    assign if_valid  = ifid_q.valid;
    assign fetch_err = err_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with the IF/ID pipeline register. Holds the PC, drives instruction-memory reads, handles stalls, redirects from execute, and halts, and presents a registered instruction and its PC+2 to decode. Decode's control logic consumes `if_instr[15:11]` as its opcode. A bubble is always the NOP encoding.

## Interface
- `WIDTH`, 16, instruction/address width
- `RESET_PC`, 16'h0000, PC value after reset
- `NOP_INSTR`, 16'h0800, bubble encoding (opcode 00001)

- `clk`  in  1  — single clock; all state updates on rising edge
- `rst`  in  1  — reset; synchronous, active-high
- `imem_addr`  out  WIDTH  — current PC, valid while `imem_rd`=1
- `imem_rd`  out  1  — fetch request
- `imem_data`  in  WIDTH  — instruction word, combinational from memory
- `imem_ready`  in  1  — `imem_data` valid this cycle
- `stall`  in  1  — hazard unit: hold PC and IF/ID
- `redirect`  in  1  — taken branch/jump from execute
- `redirect_pc`  in  WIDTH  — target PC
- `if_instr`  out  WIDTH  — IF/ID instruction
- `if_pc2`  out  WIDTH  — IF/ID PC+2 of that instruction
- `if_valid`  out  1  — IF/ID holds a real instruction
- `fetch_err`  out  1  — sticky misaligned-redirect flag

## Operation
- **Reset values** (cycle after `rst`=1): pc=`RESET_PC`, `if_instr`=`NOP_INSTR`, `if_pc2`=0, `if_valid`=0, `fetch_err`=0, state RUN.
- **FSM states:** RUN, HALTED, ERR.
- `imem_rd` = (state==RUN). `imem_addr` = pc.
- **Edge priority, highest first:**
  1. `rst`: apply the reset values.
  2. **ERR:** hold everything. Leave ERR only by `rst`.
  3. **`redirect` with `redirect_pc[0]`=1:** fetch_err<=1, state<=ERR, IF/ID<=bubble, pc unchanged.
  4. **`redirect` aligned:** pc<=`redirect_pc`, IF/ID<=bubble (NOP, valid 0, pc2 0), state<=RUN. This applies from any non-ERR state and overrides `stall`.
  5. **`stall`:** pc, IF/ID and state all hold.
  6. **HALTED:** IF/ID<=bubble, pc holds.
  7. **RUN with `imem_ready`=0:** IF/ID<=bubble, pc holds.
  8. **RUN with `imem_ready`=1 and `imem_data[15:11]`=5'b00000 (HALT):**
     - IF/ID<=`imem_data`, pc+2, valid 1.
     - pc holds at the HALT address.
     - state<=HALTED.
  9. **RUN with `imem_ready`=1, other opcode:** IF/ID<=`imem_data`, pc+2, valid 1; pc<=pc+2.
- **Bubble** = `if_instr`=`NOP_INSTR`, `if_valid`=0, `if_pc2`=0.
- **Arithmetic:** pc+2 is modulo 2^WIDTH, so 16'hFFFE+2=16'h0000. No flag is raised on wrap.
- **HALTED squash:** a HALT on a wrong path is squashed by a later redirect, which returns the FSM to RUN. The pipeline asserts `redirect` while the HALT is still younger than the branch.

## Timing
- **Latency:** an instruction presented with `imem_ready`=1 at edge N appears on `if_instr` after edge N. Throughput is 1 per cycle with no stall.
- **Redirect:** takes effect at the same edge. The first target fetch is requested in cycle N+1, and target data reaches IF/ID after edge N+1.
- **Redirect + stall, same cycle:** redirect wins. The IF/ID content is discarded, not held.
- **Stall + `imem_ready`=0:** stall holds; the existing IF/ID is not replaced by a bubble.
- **`rst` mid-operation:** overrides any pending redirect or stall.
- **Output register:** `imem_rd` and `imem_addr` depend only on registered state; no combinational path exists from inputs to them.

## Test plan
- **Reset, then straight-line fetch:**
  - Stimulus: release `rst`; memory returns 0x4001, 0x4202, 0x0800 with ready=1.
  - Required: `imem_addr` steps 0,2,4; `if_instr` follows one cycle later with `if_pc2`=2,4,6 and valid=1.
- **Stall:**
  - Stimulus: assert `stall` 2 cycles at pc=4.
  - Required: `imem_addr` stays 4; `if_instr`/`if_pc2` hold; fetch resumes at 4 on release.
- **Redirect during stall:**
  - Stimulus: `stall`=1, `redirect`=1, `redirect_pc`=0x0100.
  - Required: next cycle pc=0x0100, `if_valid`=0, `if_instr`=0x0800.
- **Halt, then squash:**
  - Stimulus: fetch 0x0000 at pc=6.
  - Required: IF/ID=0x0000, `if_pc2`=8, `imem_rd`=0, pc stays 6, bubbles follow.
  - Stimulus: then `redirect` to 0x0020.
  - Required: `imem_rd`=1 at 0x0020.
- **Memory not ready:**
  - Stimulus: `imem_ready`=0 for 3 cycles at pc=0x0010.
  - Required: 3 bubbles; pc stays 0x0010; 0x0010 is fetched when ready returns.
- **Misaligned redirect and wrap:**
  - Stimulus: `redirect_pc`=0x0033.
  - Required: `fetch_err`=1, `imem_rd`=0 until `rst`.
  - Stimulus: separately, fetch at 0xFFFE.
  - Required: `if_pc2`=0x0000, next pc=0x0000.
